// File: rtl/dec_scan_sequencer_if.sv
// Control/status bundle between a scan controller and dec_scan_sequencer.
// The sequencer side is the slave; sel/sel_en feed the 3:8 decoder directly.
interface dec_scan_sequencer_if #(
  parameter int DWELL_W = 8
);
  logic               start;
  logic               stop;
  logic [7:0]         mask;
  logic [DWELL_W-1:0] dwell;
  logic               one_shot;
  logic [2:0]         sel;
  logic               sel_en;
  logic               busy;
  logic               done;
  logic               wrap;

  modport master (
    output start, stop, mask, dwell, one_shot,
    input  sel, sel_en, busy, done, wrap
  );

  modport slave (
    input  start, stop, mask, dwell, one_shot,
    output sel, sel_en, busy, done, wrap
  );
endinterface

// File: rtl/dec_scan_sequencer.sv
// Steps a 3-bit decoder select over the channels of a latched mask, holding each
// channel for dwell+1 cycles, in one-shot or continuous (wrapping) mode.
//
// state | meaning
// IDLE  | no channel selected; waiting for start with a non-zero mask
// SCAN  | sel_en high; counting down dwell on the current channel
module dec_scan_sequencer #(
  parameter int DWELL_W = 8
) (
  input logic                clk,
  input logic                rst_n,
  dec_scan_sequencer_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [2:0]         sel_q, sel_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [7:0]         mask_q, mask_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               one_shot_q, one_shot_d;
  logic               done_q, done_d;
  logic               wrap_q, wrap_d;

  logic [2:0] low_in, low_q, next_q;
  logic       has_next;

  // Priority searches: lowest set bit of the live and latched masks, and the
  // first latched bit strictly above the current channel.
  always_comb begin
    logic found_in, found_q;
    low_in   = '0;
    low_q    = '0;
    next_q   = '0;
    has_next = 1'b0;
    found_in = 1'b0;
    found_q  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.mask[i] && !found_in) begin
        low_in   = 3'(i);
        found_in = 1'b1;
      end
      if (mask_q[i] && !found_q) begin
        low_q   = 3'(i);
        found_q = 1'b1;
      end
      if (mask_q[i] && (3'(i) > sel_q) && !has_next) begin
        next_q   = 3'(i);
        has_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      cnt_q      <= '0;
      mask_q     <= '0;
      dwell_q    <= '0;
      one_shot_q <= 1'b0;
      done_q     <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      mask_q     <= mask_d;
      dwell_q    <= dwell_d;
      one_shot_q <= one_shot_d;
      done_q     <= done_d;
      wrap_q     <= wrap_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    mask_d     = mask_q;
    dwell_d    = dwell_q;
    one_shot_d = one_shot_q;
    done_d     = 1'b0;
    wrap_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start && (bus.mask != 8'h00)) begin
          state_d    = SCAN;
          mask_d     = bus.mask;
          dwell_d    = bus.dwell;
          one_shot_d = bus.one_shot;
          sel_d      = low_in;
          cnt_d      = bus.dwell;
        end
      end
      SCAN: begin
        // stop wins over a channel end in the same cycle
        if (bus.stop) begin
          state_d = IDLE;
          sel_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (has_next) begin
          sel_d = next_q;
          cnt_d = dwell_q;
        end else if (!one_shot_q) begin
          sel_d  = low_q;
          cnt_d  = dwell_q;
          wrap_d = 1'b1;
        end else begin
          state_d = IDLE;
          sel_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.sel    = sel_q;
  assign bus.busy   = (state_q == SCAN);
  assign bus.sel_en = (state_q == SCAN);
  assign bus.done   = done_q;
  assign bus.wrap   = wrap_q;
endmodule
